// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-to-read bypass and a per-register busy scoreboard.
// All outputs are registered; reads take one cycle and hold while their enable is low.
module regfile_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned NRD     = 2,
  parameter int unsigned ZERO_R0 = 1,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD-1:0]      rd_en_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                we_i,
  input  logic [AW-1:0]       wr_addr_i,
  input  logic [XLEN-1:0]     wr_data_i,
  input  logic                sb_set_i,
  input  logic [AW-1:0]       sb_addr_i,
  output logic [NREGS-1:0]    busy_vec_o
);

  localparam logic [AW:0] NRegsW = (AW+1)'(NREGS);

  // True for addresses that map to real, writable storage.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NRegsW) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    busy_q, busy_d;
  logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]      rd_busy_q, rd_busy_d;
  logic                wr_ok, sb_ok;
  logic [AW-1:0]       ra;

  assign wr_ok = addr_ok(wr_addr_i);
  assign sb_ok = addr_ok(sb_addr_i);

  // A set and a clear on the same register leave it busy: the new producer wins.
  always_comb begin
    busy_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      busy_d[i] = (busy_q[i] & ~(we_i & (wr_addr_i == AW'(i))))
                | (sb_set_i & sb_ok & (sb_addr_i == AW'(i)));
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    ra        = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      if (rd_en_i[p]) begin
        ra = rd_addr_i[p*AW +: AW];
        if (!addr_ok(ra)) begin
          rd_data_d[p*XLEN +: XLEN] = '0;
          rd_busy_d[p]              = 1'b0;
        end else begin
          if ((BYPASS != 0) && we_i && (wr_addr_i == ra)) begin
            rd_data_d[p*XLEN +: XLEN] = wr_data_i;
          end else begin
            rd_data_d[p*XLEN +: XLEN] = regs_q[ra];
          end
          rd_busy_d[p] = (BYPASS != 0) ? busy_d[ra] : busy_q[ra];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      if (we_i && wr_ok) begin
        regs_q[wr_addr_i] <= wr_data_i;
      end
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_busy_o  = rd_busy_q;
  assign busy_vec_o = busy_q;

endmodule
